// File: rtl/key_pulse_stretcher.sv
// rtl/key_pulse_stretcher.sv - per-channel one-clock event to fixed-length pulse stretcher with event queue
// Optional sticky overflow flags per channel when KEY_PULSE_STRETCHER_OVF_EN is defined.
`timescale 1ns/1ps
module key_pulse_stretcher #(
  parameter int CHANNELS   = 5,
  parameter int ON_CYCLES  = 4000000,
  parameter int GAP_CYCLES = 2000000,
  parameter int PEND_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy
`ifdef KEY_PULSE_STRETCHER_OVF_EN
  ,
  output logic [CHANNELS-1:0] ovf
`endif
);

  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [TIMER_W-1:0]  timer_q [CHANNELS];
  logic [TIMER_W-1:0]  timer_d [CHANNELS];
  logic [PEND_W-1:0]   pend_q  [CHANNELS];
  logic [PEND_W-1:0]   pend_d  [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] busy_q;
  logic [CHANNELS-1:0] busy_d;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;
`endif

  always_comb begin
    out_d  = '0;
    busy_d = '0;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
    ovf_d  = ovf_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      pend_d[i]  = pend_q[i];

      case (state_q[i])
        ST_IDLE: begin
          if (in[i]) begin
            state_d[i] = ST_ON;
            timer_d[i] = ON_LOAD;
          end
        end

        ST_ON: begin
          if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - 1'b1;
          end else begin
            state_d[i] = ST_GAP;
            timer_d[i] = GAP_LOAD;
          end
          if (in[i]) begin
            if (pend_q[i] != PEND_MAX) begin
              pend_d[i] = pend_q[i] + 1'b1;
            end
`ifdef KEY_PULSE_STRETCHER_OVF_EN
            else begin
              ovf_d[i] = 1'b1;
            end
`endif
          end
        end

        ST_GAP: begin
          if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - 1'b1;
            if (in[i]) begin
              if (pend_q[i] != PEND_MAX) begin
                pend_d[i] = pend_q[i] + 1'b1;
              end
`ifdef KEY_PULSE_STRETCHER_OVF_EN
              else begin
                ovf_d[i] = 1'b1;
              end
`endif
            end
          end else if (pend_q[i] != '0) begin
            // A new event on the dequeue edge replaces the one being served.
            state_d[i] = ST_ON;
            timer_d[i] = ON_LOAD;
            if (!in[i]) begin
              pend_d[i] = pend_q[i] - 1'b1;
            end
          end else if (in[i]) begin
            state_d[i] = ST_ON;
            timer_d[i] = ON_LOAD;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end

        default: begin
          state_d[i] = ST_IDLE;
          timer_d[i] = '0;
          pend_d[i]  = '0;
        end
      endcase

      out_d[i]  = (state_d[i] == ST_ON);
      busy_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
        pend_q[i]  <= '0;
      end
      out_q  <= '0;
      busy_q <= '0;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
      ovf_q  <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        pend_q[i]  <= pend_d[i];
      end
      out_q  <= out_d;
      busy_q <= busy_d;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_key_pulse_stretcher.sv
// tb/tb_key_pulse_stretcher.sv - scoreboard bench for key_pulse_stretcher against a pulse-schedule model
`timescale 1ns/1ps
module tb_key_pulse_stretcher;

  localparam int CH   = 5;
  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in_v = '0;
  logic [CH-1:0] out;
  logic [CH-1:0] busy;
`ifdef KEY_PULSE_STRETCHER_OVF_EN
  logic [CH-1:0] ovf;
`endif

  key_pulse_stretcher #(
    .CHANNELS  (CH),
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .PEND_W    (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_v),
    .out  (out),
    .busy (busy)
`ifdef KEY_PULSE_STRETCHER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH-1:0] out;
    logic [CH-1:0] busy;
    logic [CH-1:0] ovf;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Model: each accepted event owns a start edge; a pulse is ON for edges
  // [s, s+ON) and busy for [s, s+ON+GAP). Pending = starts still in the future.
  int starts [CH][$];
  int first_drop [CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      starts[c].delete();
      first_drop[c] = -1;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] v, input int e);
    exp_t x;
    int   cnt;
    int   s;
    x.out  = '0;
    x.busy = '0;
    x.ovf  = '0;
    for (int c = 0; c < CH; c++) begin
      while (starts[c].size() > 1 && starts[c][0] + ON + GAP <= e) void'(starts[c].pop_front());
      if (v[c]) begin
        cnt = 0;
        for (int k = 0; k < starts[c].size(); k++) if (starts[c][k] > e) cnt++;
        if (cnt == PMAX) begin
          if (first_drop[c] < 0) first_drop[c] = e;
        end else begin
          s = e;
          if (starts[c].size() > 0 && starts[c][$] + ON + GAP > s) s = starts[c][$] + ON + GAP;
          starts[c].push_back(s);
        end
      end
      for (int k = 0; k < starts[c].size(); k++) begin
        if (starts[c][k] <= e && e < starts[c][k] + ON)       x.out[c]  = 1'b1;
        if (starts[c][k] <= e && e < starts[c][k] + ON + GAP) x.busy[c] = 1'b1;
      end
      x.ovf[c] = (first_drop[c] >= 0);
    end
    sb_q.push_back(x);
  endtask

  task automatic step(input logic [CH-1:0] v);
    @(negedge clk);
    in_v = v;
    if (sb_en) model_edge(v, cyc + 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef KEY_PULSE_STRETCHER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_v  = '0;
    model_clear();
    sb_en = 1'b1;
    model_edge('0, cyc + 1);
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (sb_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        x = sb_q.pop_front();
        chk("out", 32'(out), 32'(x.out));
        chk("busy", 32'(busy), 32'(x.busy));
`ifdef KEY_PULSE_STRETCHER_OVF_EN
        chk("ovf", 32'(ovf), 32'(x.ovf));
`endif
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    release_reset();
    repeat (20) step('0);

    // single event on channel 0
    step(5'b00001);
    repeat (8) step('0);

    // three back-to-back events on channel 1
    repeat (3) step(5'b00010);
    repeat (20) step('0);

    // six events on channel 2: one served, three queued, two dropped
    repeat (6) step(5'b00100);
    repeat (30) step('0);

    // channel 3: event on the GAP-to-IDLE edge, then on a GAP-to-ON edge
    step(5'b01000);
    repeat (5) step('0);
    step(5'b01000);
    repeat (10) step('0);
    step(5'b01000);
    step(5'b01000);
    repeat (4) step('0);
    step(5'b01000);
    repeat (25) step('0);

    // randomized traffic, alternating sparse and bursty phases
    for (int p = 0; p < 8; p++) begin
      for (int n = 0; n < 200; n++) begin
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++)
          v[c] = (p % 2 == 0) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
        step(v);
      end
    end
    repeat (40) step('0);

    // asynchronous reset while channel 4 is ON with one event queued
    step(5'b10000);
    step(5'b10000);
    step('0);
    @(posedge clk);
    #3;
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    sb_q.delete();
    release_reset();
    repeat (15) step('0);

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
